// File: rtl/rv_fetch_buf.sv
// Instruction fetch stage: issues sequential word fetches on a req/gnt/rvalid port,
// buffers returned words with their pc in a small FIFO and hands them to the decoder.
module rv_fetch_buf #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_pc_q    [DEPTH];

    logic [CW:0]   credit_used;
    logic          accept, rsp, push, pop;
    logic [31:0]   redirect_pc;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^redirect_addr_i[1:0];
    assign redirect_pc      = {redirect_addr_i[31:2], 2'b00};

    // Outstanding requests (discards included) and buffered words share one credit pool,
    // so a returning word always finds a free FIFO slot.
    assign credit_used   = {1'b0, outst_q} + {1'b0, count_q};
    assign imem_req_o    = !rst_i && !redirect_i && (credit_used < DEPTH_C);
    assign imem_addr_o   = pc_q;
    assign accept        = imem_req_o && imem_gnt_i;
    assign rsp           = imem_rvalid_i && (outst_q != '0);
    assign push          = rsp && (discard_q == '0) && !redirect_i;
    assign instr_valid_o = (count_q != '0) && !rst_i;
    assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
    assign instr_o       = instr_valid_o ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign instr_pc_o    = instr_valid_o ? fifo_pc_q[rd_ptr_q]    : 32'h0;

    always_comb begin
        pc_d      = accept ? pc_q + 32'd4 : pc_q;
        rsp_pc_d  = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
        outst_d   = outst_q + CW'(accept) - CW'(rsp);
        discard_d = (rsp && (discard_q != '0)) ? discard_q - CW'(1) : discard_q;
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_i) begin
            pc_d      = redirect_pc;
            rsp_pc_d  = redirect_pc;
            discard_d = outst_d;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= RESET_ADDR;
            rsp_pc_q  <= RESET_ADDR;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
            fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

endmodule
